obstacle_field_ctrl: RTL and testbench



---
 rtl/obstacle_pkg.sv | 27 ++
 rtl/obstacle_channel.sv | 140 ++++++++++++++
 rtl/obstacle_field_ctrl.sv | 96 +++++++++
 tb/tb_obstacle_field_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle trajectory engine.
// Holds the channel lifecycle enum, the edge bit layout and a saturating clamp.
package obstacle_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DYING  = 2'd1,
        DEAD   = 2'd2
    } obst_state_t;

    // Bit positions inside one channel's {Left,Top,Right,Bottom} edge code
    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;

    localparam int FRAME_CNT_W = 8;

    function automatic logic signed [31:0] clamp_s32(input logic signed [31:0] v,
                                                     input logic signed [31:0] lo,
                                                     input logic signed [31:0] hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

endpackage

// File: rtl/obstacle_channel.sv
// One obstacle: fixed-point motion with reflection, gravity and saturation,
// sticky edge latching, and the ACTIVE/DYING/DEAD lifecycle.
module obstacle_channel
    import obstacle_pkg::*;
#(
    parameter int FRAC_BITS      = 6,
    parameter int X_MIN          = 30,
    parameter int X_MAX          = 545,
    parameter int Y_MIN          = 30,
    parameter int Y_MAX          = 441,
    parameter int START_X        = 40,
    parameter int START_Y        = 60,
    parameter int START_VX       = 40,
    parameter int START_VY       = 20,
    parameter int Y_ACCEL        = 0,
    parameter int MAX_SPEED      = 400,
    parameter int BLINK_FRAMES   = 16,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               sof_i,
    input  logic               collision_i,
    input  logic [3:0]         hit_edge_i,
    input  logic               shoot_hit_i,
    input  logic               armed_i,
    output logic signed [10:0] x_o,
    output logic signed [10:0] y_o,
    output logic               enable_o,
    output obst_state_t        state_o
);

    localparam int XLO        = X_MIN << FRAC_BITS;
    localparam int XHI        = X_MAX << FRAC_BITS;
    localparam int YLO        = Y_MIN << FRAC_BITS;
    localparam int YHI        = Y_MAX << FRAC_BITS;
    localparam int X_START_FP = START_X << FRAC_BITS;
    localparam int Y_START_FP = START_Y << FRAC_BITS;
    localparam logic [FRAME_CNT_W-1:0] BLINK_LAST = FRAME_CNT_W'(BLINK_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] RESP_LAST  = FRAME_CNT_W'(RESPAWN_FRAMES - 1);

    logic signed [31:0]     pos_x_q, pos_y_q, vx_q, vy_q;
    logic signed [31:0]     pos_x_d, pos_y_d, vx_d, vy_d;
    logic [3:0]             sticky_q;
    obst_state_t            state_q;
    logic [FRAME_CNT_W-1:0] frame_q;
    logic [FRAME_CNT_W-1:0] frame_inc;
    logic                   enable_q;

    assign frame_inc = frame_q + 1'b1;

    // Sign tests use the current speed, so at most one reflection per axis per frame
    always_comb begin
        vx_d = vx_q;
        if (((pos_x_q <= XLO) || sticky_q[EDGE_LEFT]) && (vx_q < 0))
            vx_d = -vx_q;
        else if (((pos_x_q >= XHI) || sticky_q[EDGE_RIGHT]) && (vx_q > 0))
            vx_d = -vx_q;
        vx_d = clamp_s32(vx_d, -MAX_SPEED, MAX_SPEED);

        vy_d = vy_q;
        if (((pos_y_q <= YLO) || sticky_q[EDGE_TOP]) && (vy_q <= 0))
            vy_d = -vy_q;
        else if (((pos_y_q >= YHI) || sticky_q[EDGE_BOTTOM]) && (vy_q >= 0))
            vy_d = -vy_q;
        vy_d = clamp_s32(vy_d + Y_ACCEL, -MAX_SPEED, MAX_SPEED);

        pos_x_d = clamp_s32(pos_x_q + vx_d, XLO, XHI);
        pos_y_d = clamp_s32(pos_y_q + vy_d, YLO, YHI);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_x_q  <= X_START_FP;
            pos_y_q  <= Y_START_FP;
            vx_q     <= START_VX;
            vy_q     <= START_VY;
            sticky_q <= '0;
            state_q  <= ACTIVE;
            frame_q  <= '0;
            enable_q <= 1'b1;
        end else begin
            // A collision arriving on the frame cycle itself survives into the next frame
            if (sof_i)
                sticky_q <= collision_i ? hit_edge_i : 4'b0000;
            else if (collision_i)
                sticky_q <= sticky_q | hit_edge_i;

            if (sof_i && (state_q != DEAD)) begin
                pos_x_q <= pos_x_d;
                pos_y_q <= pos_y_d;
                vx_q    <= vx_d;
                vy_q    <= vy_d;
            end

            if (sof_i)
                frame_q <= frame_inc;

            case (state_q)
                ACTIVE: begin
                    if (shoot_hit_i && armed_i) begin
                        state_q  <= DYING;
                        frame_q  <= '0;
                        enable_q <= 1'b0;
                    end
                end
                DYING: begin
                    if (sof_i) begin
                        if (frame_q == BLINK_LAST) begin
                            state_q  <= DEAD;
                            frame_q  <= '0;
                            enable_q <= 1'b0;
                        end else begin
                            enable_q <= frame_inc[1];
                        end
                    end
                end
                DEAD: begin
                    if (sof_i && (RESPAWN_FRAMES != 0) && (frame_q == RESP_LAST)) begin
                        state_q  <= ACTIVE;
                        frame_q  <= '0;
                        enable_q <= 1'b1;
                        pos_x_q  <= X_START_FP;
                        pos_y_q  <= Y_START_FP;
                        vx_q     <= START_VX;
                        vy_q     <= START_VY;
                        sticky_q <= '0;
                    end
                end
                default: state_q <= ACTIVE;
            endcase
        end
    end

    assign x_o      = 11'(pos_x_q >>> FRAC_BITS);
    assign y_o      = 11'(pos_y_q >>> FRAC_BITS);
    assign enable_o = enable_q;
    assign state_o  = state_q;

endmodule

// File: rtl/obstacle_field_ctrl.sv
// Multi-channel obstacle engine: NUM_OBST independent channels plus the shared
// arm counter, alive popcount and the all-cleared pulse.
module obstacle_field_ctrl
    import obstacle_pkg::*;
#(
    parameter int NUM_OBST       = 4,
    parameter int FRAC_BITS      = 6,
    parameter int X_MIN          = 30,
    parameter int X_MAX          = 545,
    parameter int Y_MIN          = 30,
    parameter int Y_MAX          = 441,
    parameter int INIT_X         = 40,
    parameter int X_STRIDE       = 128,
    parameter int INIT_Y         = 60,
    parameter int INIT_XSPEED    = 40,
    parameter int INIT_YSPEED    = 20,
    parameter int Y_ACCEL        = 0,
    parameter int MAX_SPEED      = 400,
    parameter int BLINK_FRAMES   = 16,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     startOfFrame,
    input  logic [NUM_OBST-1:0]      collision,
    input  logic [4*NUM_OBST-1:0]    HitEdgeCode,
    input  logic [NUM_OBST-1:0]      shootHit,
    output logic [11*NUM_OBST-1:0]   topLeftX,
    output logic [11*NUM_OBST-1:0]   topLeftY,
    output logic [NUM_OBST-1:0]      enable_obstacle,
    output logic [3:0]               alive_count,
    output logic                     all_cleared
);

    logic [1:0]  arm_cnt_q;
    logic        armed;
    logic        alive_zero_q;
    logic        all_cleared_q;
    obst_state_t state_w [NUM_OBST];

    // Shots in the first two clocks after reset are ignored
    assign armed = (arm_cnt_q == 2'd2);

    for (genvar g = 0; g < NUM_OBST; g++) begin : g_ch
        obstacle_channel #(
            .FRAC_BITS      (FRAC_BITS),
            .X_MIN          (X_MIN),
            .X_MAX          (X_MAX),
            .Y_MIN          (Y_MIN),
            .Y_MAX          (Y_MAX),
            .START_X        (INIT_X + g * X_STRIDE),
            .START_Y        (INIT_Y),
            .START_VX       ((g % 2 == 0) ? INIT_XSPEED : -INIT_XSPEED),
            .START_VY       (INIT_YSPEED),
            .Y_ACCEL        (Y_ACCEL),
            .MAX_SPEED      (MAX_SPEED),
            .BLINK_FRAMES   (BLINK_FRAMES),
            .RESPAWN_FRAMES (RESPAWN_FRAMES)
        ) u_ch (
            .clk_i       (clk),
            .rst_ni      (resetN),
            .sof_i       (startOfFrame),
            .collision_i (collision[g]),
            .hit_edge_i  (HitEdgeCode[4*g +: 4]),
            .shoot_hit_i (shootHit[g]),
            .armed_i     (armed),
            .x_o         (topLeftX[11*g +: 11]),
            .y_o         (topLeftY[11*g +: 11]),
            .enable_o    (enable_obstacle[g]),
            .state_o     (state_w[g])
        );
    end

    always_comb begin
        alive_count = '0;
        for (int i = 0; i < NUM_OBST; i++)
            if (state_w[i] == ACTIVE)
                alive_count = alive_count + 4'd1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            arm_cnt_q     <= '0;
            alive_zero_q  <= 1'b0;
            all_cleared_q <= 1'b0;
        end else begin
            if (!armed)
                arm_cnt_q <= arm_cnt_q + 2'd1;
            alive_zero_q  <= (alive_count == 4'd0);
            all_cleared_q <= (alive_count == 4'd0) && !alive_zero_q;
        end
    end

    assign all_cleared = all_cleared_q;

endmodule

// File: tb/tb_obstacle_field_ctrl.sv
// Directed bench for obstacle_field_ctrl with default parameters; expected
// pixel values are worked out by hand from the fixed-point motion rules.
module tb_obstacle_field_ctrl;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             resetN;
    logic             startOfFrame;
    logic [N-1:0]     collision;
    logic [4*N-1:0]   HitEdgeCode;
    logic [N-1:0]     shootHit;
    logic [11*N-1:0]  topLeftX;
    logic [11*N-1:0]  topLeftY;
    logic [N-1:0]     enable_obstacle;
    logic [3:0]       alive_count;
    logic             all_cleared;

    int n_checks = 0;
    int n_pass   = 0;

    obstacle_field_ctrl dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .collision       (collision),
        .HitEdgeCode     (HitEdgeCode),
        .shootHit        (shootHit),
        .topLeftX        (topLeftX),
        .topLeftY        (topLeftY),
        .enable_obstacle (enable_obstacle),
        .alive_count     (alive_count),
        .all_cleared     (all_cleared)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        step();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    function automatic int x_of(input int ch);
        return int'($signed(topLeftX[11*ch +: 11]));
    endfunction

    function automatic int y_of(input int ch);
        return int'($signed(topLeftY[11*ch +: 11]));
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        collision    = '0;
        HitEdgeCode  = '0;
        shootHit     = '0;
        step();
        step();
    endtask

    initial begin
        do_reset();
        check("rst_x0", x_of(0), 40);
        check("rst_x1", x_of(1), 168);
        check("rst_x2", x_of(2), 296);
        check("rst_x3", x_of(3), 424);
        check("rst_y0", y_of(0), 60);
        check("rst_y3", y_of(3), 60);
        check("rst_enable", int'(enable_obstacle), 15);
        check("rst_alive", int'(alive_count), 4);
        check("rst_cleared", int'(all_cleared), 0);
        resetN = 1'b1;

        shootHit = 4'b0100;
        step();
        shootHit = '0;
        check("unarmed_alive", int'(alive_count), 4);
        check("unarmed_enable", int'(enable_obstacle), 15);

        frame();
        check("f1_x0", x_of(0), 40);
        check("f1_x1_floor", x_of(1), 167);
        check("f1_x2", x_of(2), 296);
        check("f1_x3_floor", x_of(3), 423);
        check("f1_y0", y_of(0), 60);

        shootHit = 4'b0100;
        step();
        shootHit = '0;
        check("shot_alive", int'(alive_count), 3);
        check("shot_enable", int'(enable_obstacle), 4'b1011);

        for (int k = 1; k <= 15; k++) begin
            frame();
            check("blink", int'(enable_obstacle[2]), (k >> 1) & 1);
        end
        frame();
        check("dead_enable", int'(enable_obstacle[2]), 0);
        check("dead_alive", int'(alive_count), 3);

        frames(59);
        check("dead_hold_enable", int'(enable_obstacle[2]), 0);
        check("dead_frozen_x2", x_of(2), 306);
        check("dead_frozen_y2", y_of(2), 65);

        startOfFrame = 1'b1;
        shootHit     = 4'b0100;
        step();
        startOfFrame = 1'b0;
        shootHit     = '0;
        check("respawn_x2", x_of(2), 296);
        check("respawn_y2", y_of(2), 60);
        check("respawn_enable", int'(enable_obstacle[2]), 1);
        check("respawn_alive", int'(alive_count), 4);
        step();

        for (int i = 0; i < N; i++) begin
            shootHit = 4'(1 << i);
            step();
            shootHit = '0;
            check("seq_alive", int'(alive_count), 3 - i);
            check("seq_cleared_low", int'(all_cleared), 0);
        end
        check("seq_enable", int'(enable_obstacle), 0);
        step();
        check("cleared_pulse", int'(all_cleared), 1);
        step();
        check("cleared_end", int'(all_cleared), 0);

        do_reset();
        resetN = 1'b1;
        collision   = 4'b0001;
        HitEdgeCode = 16'h0008;
        step();
        collision   = '0;
        HitEdgeCode = '0;
        startOfFrame = 1'b1;
        collision    = 4'b0001;
        HitEdgeCode  = 16'h0001;
        step();
        startOfFrame = 1'b0;
        collision    = '0;
        HitEdgeCode  = '0;
        step();
        check("stk_f1_x0", x_of(0), 40);
        check("stk_f1_y0", y_of(0), 60);
        frame();
        check("stk_f2_x0", x_of(0), 41);
        check("stk_f2_y0", y_of(0), 60);
        collision   = 4'b0001;
        HitEdgeCode = 16'h0002;
        step();
        collision   = '0;
        HitEdgeCode = '0;
        frame();
        check("stk_f3_x0", x_of(0), 40);
        check("stk_f3_y0", y_of(0), 59);
        check("stk_f3_y1", y_of(1), 60);
        frame();
        check("stk_f4_x0", x_of(0), 40);
        check("stk_f4_y0", y_of(0), 59);
        frame();
        check("stk_f5_x0", x_of(0), 39);

        do_reset();
        resetN = 1'b1;
        frames(221);
        check("b221_x1_clamp", x_of(1), 30);
        frame();
        check("b222_x1", x_of(1), 30);
        frame();
        check("b223_x1", x_of(1), 31);
        frames(176);
        check("b399_x2_clamp", x_of(2), 545);
        frame();
        check("b400_x2", x_of(2), 544);
        frames(408);
        check("b808_x0", x_of(0), 545);
        check("b808_x1", x_of(1), 396);
        check("b808_x2", x_of(2), 289);
        check("b808_x3", x_of(3), 140);
        check("b808_y0", y_of(0), 312);
        frame();
        check("b809_x0", x_of(0), 544);
        frames(411);
        check("b1220_y0_clamp", y_of(0), 441);
        frame();
        check("b1221_y0", y_of(0), 440);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
